tsu_axis_ptp_ts: RTL and testbench
==================================

TSU_AXIS_PTP_TS -- requirements
Module: tsu_axis_ptp_ts

Interface
REQ-001 SHALL have parameter DATA_W, default 8, AXIS data width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter TS_W, default 64, RTC timestamp width in bits (1 ns per LSB).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, timestamp FIFO entries; must be a power of 2 and at least 2.
REQ-004 SHALL have port mac_axis_aclk, in, 1 bit: the single clock. All ports are synchronous to it, including rtc_timer_in.
REQ-005 SHALL have port mac_axis_resetn, in, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports s_axis_tdata/tvalid/tready/tlast, in/in/out/in, DATA_W/1/1/1 bits: frame input; byte 0 is in lane 0.
REQ-007 SHALL have ports m_axis_tdata/tvalid/tready/tlast, out/out/in/out, DATA_W/1/1/1 bits: frame output.
REQ-008 SHALL have port rtc_timer_in, in, TS_W bits: free-running RTC value.
REQ-009 SHALL have port ts_tdata, out, TS_W+20 bits, packed as {msg_type[3:0], seq_id[15:0], timestamp}.
REQ-010 SHALL have ports ts_tvalid, out, 1 bit, and ts_tready, in, 1 bit: timestamp record handshake.
REQ-011 SHALL have port ts_fifo_level, out, log2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-012 SHALL have port ts_overflow_cnt, out, 16 bits: count of dropped records; saturates at 0xFFFF.
REQ-013 SHALL have port frame_cnt, out, 32 bits: count of completed frames; wraps to 0 after 0xFFFFFFFF.

Function
REQ-014 SHALL pass the data path through combinationally with zero latency: m_axis_tdata/tvalid/tlast equal the s_axis inputs, and s_axis_tready equals m_axis_tready.
REQ-015 SHALL count a beat only on handshake, meaning tvalid and tready both high in the same cycle.
REQ-016 SHALL implement parser FSM states IDLE, IN_FRAME and DROP, and SHALL enter IDLE on reset.
REQ-017 IDLE: on the first beat handshake, SHALL latch rtc_timer_in from that same cycle as the SOF timestamp, clear the byte offset to 0, and go to IN_FRAME; if that beat also has tlast, SHALL go to IDLE instead.
REQ-018 SHALL compute frame byte offset as beat_index*(DATA_W/8)+lane; the beat index saturates at 255, and no bytes beyond offset 63 are inspected.
REQ-019 SHALL capture bytes 12-13 as the EtherType; if the EtherType is 0x8100 (VLAN tag), SHALL shift all later offsets by +4 and use bytes 16-17 as the EtherType.
REQ-020 SHALL classify a frame as PTP-event when EtherType = 0x88F7 and msg_type = low nibble of PTP byte 0 is in the range 0x0 to 0x3.
REQ-021 SHALL take seq_id from PTP header bytes 30-31, big-endian, where PTP byte 0 is at frame offset 14 (or 18 when VLAN-tagged).
REQ-022 SHALL go from IN_FRAME to DROP when the EtherType is known and is not 0x88F7; in DROP it SHALL only wait for tlast.
REQ-023 On the tlast handshake in IN_FRAME, SHALL push the record {msg_type, seq_id, SOF timestamp} if the frame classified as PTP-event and seq_id was fully received; otherwise SHALL push nothing. The next state is IDLE.
REQ-024 A frame ending before seq_id is fully received (truncated) SHALL push nothing and SHALL NOT raise an error.
REQ-025 SHALL increment frame_cnt by 1 on every tlast handshake, in any state.
REQ-026 SHALL write a FIFO push at the clock edge of the tlast handshake; ts_tvalid SHALL be high from the next cycle.
REQ-027 FIFO read SHALL be first-word-fall-through: ts_tdata is valid whenever ts_tvalid is high, and a pop occurs on the ts_tvalid and ts_tready handshake.
REQ-028 Full and no pop in the same cycle: SHALL drop the record, leave FIFO contents unchanged, and increment ts_overflow_cnt.
REQ-029 Full with a pop in the same cycle: SHALL accept the push and keep the level unchanged.
REQ-030 Empty with a push in the same cycle: SHALL NOT allow a pop in that cycle (ts_tvalid is still low).
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the level SHALL always be in the range 0 to FIFO_DEPTH.

Reset
REQ-032 Asserting mac_axis_resetn low SHALL clear, asynchronously: the FSM to IDLE, the FIFO pointers and level, ts_tvalid, both counters, and the SOF timestamp register.
REQ-033 During reset, the data path SHALL stay transparent, with no reset dependency.
REQ-034 A reset mid-frame SHALL discard the partial parse; the first beat after reset release SHALL be treated as SOF.

Structure
REQ-035 Shared package tsu_pkg SHALL hold: the PTP EtherType constant 0x88F7, the VLAN TPID 0x8100, the byte offsets (12, 14, 30), and the record field widths and packing.
REQ-036 The FIFO SHALL be the sub-module tsu_ts_fifo, parameterised by width and depth, with FWFT read, level output and full/empty flags.

Verification
REQ-037 DATA_W=8: Sync frame (EtherType 0x88F7, msg 0x0, seq 0x1234) with SOF at rtc=1000 -> one record {0x0, 0x1234, 1000}, ts_tvalid high the cycle after tlast, frame_cnt=1.
REQ-038 DATA_W=64: VLAN-tagged Delay_Req (msg 0x1, seq 0xBEEF) with m_axis_tready toggling every cycle -> record {0x1, 0xBEEF, rtc value at the first accepted beat}, output data identical to input.
REQ-039 IPv4 frame (0x0800), a PTP Announce (msg 0xB), and a PTP frame truncated at 40 bytes -> no records, frame_cnt=3.
REQ-040 FIFO_DEPTH=4, ts_tready=0, 6 Sync frames -> level=4, ts_overflow_cnt=2, the first 4 seq_ids read in order afterwards.
REQ-041 Full FIFO with a pop in the same cycle as a tlast push -> level stays 4, new record is last out, no overflow increment.
REQ-042 Reset asserted at byte 20 of a PTP frame, released, then a full Sync frame (seq 7) -> exactly one record with seq 7, counters restarting from 0.

Source files
------------

// File: rtl/tsu_pkg.sv
// Shared constants, parser state encoding and record layout for the PTP timestamp unit.
package tsu_pkg;
   localparam logic [15:0] ETH_TYPE_PTP  = 16'h88F7;
   localparam logic [15:0] ETH_TPID_VLAN = 16'h8100;
   localparam int unsigned OFF_ETYPE     = 12;
   localparam int unsigned OFF_PTP       = 14;
   localparam int unsigned OFF_SEQ       = 30;
   localparam int unsigned VLAN_SHIFT    = 4;
   localparam int unsigned MSG_W         = 4;
   localparam int unsigned SEQ_W         = 16;
   localparam int unsigned HDR_W         = MSG_W + SEQ_W;
   localparam logic [MSG_W-1:0] MSG_EVENT_MAX = 4'h3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_FRAME = 2'd1,
      DROP     = 2'd2
   } parse_state_t;

   // Upper part of a timestamp record; the SOF timestamp sits below it.
   typedef struct packed {
      logic [MSG_W-1:0] msg_type;
      logic [SEQ_W-1:0] seq_id;
   } ts_hdr_t;

   // Header bytes captured at both the untagged and the VLAN-shifted offsets.
   typedef struct packed {
      logic [15:0]      etype;
      logic [15:0]      etype_vlan;
      logic [MSG_W-1:0] msg;
      logic [MSG_W-1:0] msg_vlan;
      logic [SEQ_W-1:0] seq;
      logic [SEQ_W-1:0] seq_vlan;
   } hdr_cap_t;
endpackage

// File: rtl/tsu_ts_fifo.sv
// First-word-fall-through record FIFO with level and full/empty flags.
module tsu_ts_fifo #(
   parameter int unsigned WIDTH = 84,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop_fire_c;
   logic             wr_en_c;
   logic [LVL_W-1:0] level_n;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop_fire_c = pop && !empty;
   assign wr_en_c    = push && (!full || pop_fire_c);
   assign dout       = mem[rd_ptr];

   always_comb begin
      level_n = level;
      if (wr_en_c && !pop_fire_c)
         level_n = level + LVL_W'(1);
      else if (!wr_en_c && pop_fire_c)
         level_n = level - LVL_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_en_c)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_fire_c)
            rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_n;
         full  <= (level_n == LVL_W'(DEPTH));
         empty <= (level_n == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_c)
         mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/tsu_axis_ptp_ts.sv
// Transparent AXIS tap that timestamps PTP event frames at SOF and queues
// {msg_type, seq_id, timestamp} records.
module tsu_axis_ptp_ts
   import tsu_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned TS_W       = 64,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          mac_axis_aclk,
   input  logic                          mac_axis_resetn,
   input  logic [DATA_W-1:0]             s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          s_axis_tlast,
   output logic [DATA_W-1:0]             m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   input  logic [TS_W-1:0]               rtc_timer_in,
   output logic [TS_W+HDR_W-1:0]         ts_tdata,
   output logic                          ts_tvalid,
   input  logic                          ts_tready,
   output logic [$clog2(FIFO_DEPTH):0]   ts_fifo_level,
   output logic [15:0]                   ts_overflow_cnt,
   output logic [31:0]                   frame_cnt
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned OFF_W = 12;

   parse_state_t     state_q, state_n;
   logic [7:0]       beat_q, beat_n;
   hdr_cap_t         cap_q, cap_n;
   logic [TS_W-1:0]  sof_ts_q;
   logic [OFF_W-1:0] base_c, rcvd_c;
   logic             hs_c, push_c, drop_c;
   logic             vlan_c, etype_known_c, seq_done_c, ptp_event_c;
   logic [15:0]      etype_c;
   logic [MSG_W-1:0] msg_c;
   logic [SEQ_W-1:0] seq_c;
   ts_hdr_t          hdr_c;
   logic             fifo_full, fifo_empty;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tvalid = s_axis_tvalid;
   assign m_axis_tlast  = s_axis_tlast;
   assign s_axis_tready = m_axis_tready;
   assign hs_c          = s_axis_tvalid && m_axis_tready;

   // Capture header bytes at every offset of interest; the VLAN decision is made later.
   always_comb begin
      cap_n  = (state_q == IDLE) ? '0 : cap_q;
      base_c = (state_q == IDLE) ? '0 : OFF_W'(beat_q) * OFF_W'(NB);
      if (hs_c && state_q != DROP) begin
         for (int l = 0; l < int'(NB); l++) begin
            case (base_c + OFF_W'(l))
               OFF_W'(OFF_ETYPE):                          cap_n.etype[15:8]      = s_axis_tdata[8*l +: 8];
               OFF_W'(OFF_ETYPE + 1):                      cap_n.etype[7:0]       = s_axis_tdata[8*l +: 8];
               OFF_W'(OFF_ETYPE + VLAN_SHIFT):             cap_n.etype_vlan[15:8] = s_axis_tdata[8*l +: 8];
               OFF_W'(OFF_ETYPE + VLAN_SHIFT + 1):         cap_n.etype_vlan[7:0]  = s_axis_tdata[8*l +: 8];
               OFF_W'(OFF_PTP):                            cap_n.msg              = s_axis_tdata[8*l +: MSG_W];
               OFF_W'(OFF_PTP + VLAN_SHIFT):               cap_n.msg_vlan         = s_axis_tdata[8*l +: MSG_W];
               OFF_W'(OFF_PTP + OFF_SEQ):                  cap_n.seq[15:8]        = s_axis_tdata[8*l +: 8];
               OFF_W'(OFF_PTP + OFF_SEQ + 1):              cap_n.seq[7:0]         = s_axis_tdata[8*l +: 8];
               OFF_W'(OFF_PTP + OFF_SEQ + VLAN_SHIFT):     cap_n.seq_vlan[15:8]   = s_axis_tdata[8*l +: 8];
               OFF_W'(OFF_PTP + OFF_SEQ + VLAN_SHIFT + 1): cap_n.seq_vlan[7:0]    = s_axis_tdata[8*l +: 8];
               default: ;
            endcase
         end
      end
   end

   // Classification includes the bytes of the current beat.
   assign rcvd_c        = base_c + OFF_W'(NB);
   assign vlan_c        = (cap_n.etype == ETH_TPID_VLAN);
   assign etype_known_c = (rcvd_c >= OFF_W'(OFF_ETYPE + 2)) &&
                          (!vlan_c || rcvd_c >= OFF_W'(OFF_ETYPE + 2 + VLAN_SHIFT));
   assign etype_c       = vlan_c ? cap_n.etype_vlan : cap_n.etype;
   assign msg_c         = vlan_c ? cap_n.msg_vlan : cap_n.msg;
   assign seq_c         = vlan_c ? cap_n.seq_vlan : cap_n.seq;
   assign seq_done_c    = rcvd_c >= (vlan_c ? OFF_W'(OFF_PTP + OFF_SEQ + 2 + VLAN_SHIFT)
                                            : OFF_W'(OFF_PTP + OFF_SEQ + 2));
   assign ptp_event_c   = etype_known_c && (etype_c == ETH_TYPE_PTP) && (msg_c <= MSG_EVENT_MAX);

   always_comb begin
      state_n = state_q;
      beat_n  = beat_q;
      push_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (hs_c) begin
               beat_n  = 8'd1;
               state_n = s_axis_tlast ? IDLE : IN_FRAME;
            end
         end
         IN_FRAME: begin
            if (hs_c) begin
               if (beat_q != 8'hFF)
                  beat_n = beat_q + 8'd1;
               if (s_axis_tlast) begin
                  state_n = IDLE;
                  push_c  = ptp_event_c && seq_done_c;
               end else if (etype_known_c && etype_c != ETH_TYPE_PTP) begin
                  state_n = DROP;
               end
            end
         end
         DROP: begin
            if (hs_c && s_axis_tlast)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge mac_axis_aclk or negedge mac_axis_resetn) begin
      if (!mac_axis_resetn) begin
         state_q         <= IDLE;
         beat_q          <= '0;
         cap_q           <= '0;
         sof_ts_q        <= '0;
         frame_cnt       <= '0;
         ts_overflow_cnt <= '0;
      end else begin
         state_q <= state_n;
         beat_q  <= beat_n;
         cap_q   <= cap_n;
         if (state_q == IDLE && hs_c)
            sof_ts_q <= rtc_timer_in;
         if (hs_c && s_axis_tlast)
            frame_cnt <= frame_cnt + 32'd1;
         if (drop_c && ts_overflow_cnt != 16'hFFFF)
            ts_overflow_cnt <= ts_overflow_cnt + 16'd1;
      end
   end

   assign hdr_c.msg_type = msg_c;
   assign hdr_c.seq_id   = seq_c;
   assign ts_tvalid      = !fifo_empty;
   assign drop_c         = push_c && fifo_full && !(ts_tvalid && ts_tready);

   tsu_ts_fifo #(
      .WIDTH (TS_W + HDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (mac_axis_aclk),
      .rst_n (mac_axis_resetn),
      .push  (push_c),
      .din   ({hdr_c, sof_ts_q}),
      .pop   (ts_tready),
      .dout  (ts_tdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (ts_fifo_level)
   );
endmodule

// File: tb/tb_tsu_axis_ptp_ts.sv
// Scoreboard bench: 8-bit/depth-4 instance for classification and FIFO corners,
// 64-bit instance for a VLAN-tagged Delay_Req under back-pressure.
module tb_tsu_axis_ptp_ts;
   localparam int unsigned TS_W  = 64;
   localparam int unsigned REC_W = TS_W + 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [63:0]      rtc;
   logic             tog_b;

   logic [7:0]       sa_tdata, ma_tdata;
   logic             sa_tvalid, sa_tready, sa_tlast, ma_tvalid, ma_tready, ma_tlast;
   logic [REC_W-1:0] tsa_tdata;
   logic             tsa_tvalid, tsa_tready;
   logic [2:0]       lvla;
   logic [15:0]      ovfa;
   logic [31:0]      fcnta;

   logic [63:0]      sb_tdata, mb_tdata;
   logic             sb_tvalid, sb_tready, sb_tlast, mb_tvalid, mb_tready, mb_tlast;
   logic [REC_W-1:0] tsb_tdata;
   logic             tsb_tvalid, tsb_tready;
   logic [4:0]       lvlb;
   logic [15:0]      ovfb;
   logic [31:0]      fcntb;

   tsu_axis_ptp_ts #(.DATA_W(8), .TS_W(TS_W), .FIFO_DEPTH(4)) dut_a (
      .mac_axis_aclk(clk), .mac_axis_resetn(rst_n),
      .s_axis_tdata(sa_tdata), .s_axis_tvalid(sa_tvalid), .s_axis_tready(sa_tready), .s_axis_tlast(sa_tlast),
      .m_axis_tdata(ma_tdata), .m_axis_tvalid(ma_tvalid), .m_axis_tready(ma_tready), .m_axis_tlast(ma_tlast),
      .rtc_timer_in(rtc), .ts_tdata(tsa_tdata), .ts_tvalid(tsa_tvalid), .ts_tready(tsa_tready),
      .ts_fifo_level(lvla), .ts_overflow_cnt(ovfa), .frame_cnt(fcnta));

   tsu_axis_ptp_ts #(.DATA_W(64), .TS_W(TS_W), .FIFO_DEPTH(16)) dut_b (
      .mac_axis_aclk(clk), .mac_axis_resetn(rst_n),
      .s_axis_tdata(sb_tdata), .s_axis_tvalid(sb_tvalid), .s_axis_tready(sb_tready), .s_axis_tlast(sb_tlast),
      .m_axis_tdata(mb_tdata), .m_axis_tvalid(mb_tvalid), .m_axis_tready(mb_tready), .m_axis_tlast(mb_tlast),
      .rtc_timer_in(rtc), .ts_tdata(tsb_tdata), .ts_tvalid(tsb_tvalid), .ts_tready(tsb_tready),
      .ts_fifo_level(lvlb), .ts_overflow_cnt(ovfb), .frame_cnt(fcntb));

   int n_chk = 0;
   int n_err = 0;
   logic [7:0]       frm[$];
   logic [REC_W-1:0] exp_a[$];
   logic [REC_W-1:0] exp_b[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Record monitors: every presented-and-accepted record must match the queue head.
   always @(negedge clk) begin
      if (tsa_tvalid && tsa_tready) begin
         if (exp_a.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL a_rec: got unexpected record %0h expected none", tsa_tdata);
         end else
            check("a_rec", tsa_tdata, exp_a.pop_front());
      end
      if (tsb_tvalid && tsb_tready) begin
         if (exp_b.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL b_rec: got unexpected record %0h expected none", tsb_tdata);
         end else
            check("b_rec", tsb_tdata, exp_b.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rtc = rtc + 64'd1;
      if (tog_b) mb_tready = ~mb_tready;
   endtask

   task automatic build(input logic [15:0] et, input bit vlan, input logic [3:0] msg,
                        input logic [15:0] seq, input int len);
      int p;
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'(i * 7 + 3));
      p = vlan ? 18 : 14;
      if (vlan) begin
         frm[12] = 8'h81; frm[13] = 8'h00; frm[14] = 8'h20; frm[15] = 8'h05;
         frm[16] = et[15:8]; frm[17] = et[7:0];
      end else begin
         frm[12] = et[15:8]; frm[13] = et[7:0];
      end
      frm[p] = {4'hA, msg};
      if (p + 31 < len) begin
         frm[p+30] = seq[15:8];
         frm[p+31] = seq[7:0];
      end
   endtask

   task automatic send_a(input int nbeats, input bit pop_last, output logic [63:0] ts0);
      bit acc;
      int guard;
      ts0 = '0;
      for (int i = 0; i < nbeats; i++) begin
         sa_tdata  = frm[i];
         sa_tvalid = 1'b1;
         sa_tlast  = (i == frm.size() - 1);
         if (pop_last && sa_tlast) tsa_tready = 1'b1;
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            acc = sa_tready;
            if (acc && i == 0) ts0 = rtc;
            tick();
            guard++;
            if (!acc && guard > 100) begin
               n_chk++; n_err++;
               $display("FAIL a_send_timeout: got no handshake expected one within 100 cycles");
               sa_tvalid = 1'b0; sa_tlast = 1'b0;
               return;
            end
         end
         if (pop_last && sa_tlast) tsa_tready = 1'b0;
      end
      sa_tvalid = 1'b0;
      sa_tlast  = 1'b0;
   endtask

   task automatic send_b(output logic [63:0] ts0);
      bit acc;
      int guard;
      int nb;
      ts0 = '0;
      nb = frm.size() / 8;
      for (int i = 0; i < nb; i++) begin
         for (int l = 0; l < 8; l++) sb_tdata[8*l +: 8] = frm[8*i + l];
         sb_tvalid = 1'b1;
         sb_tlast  = (i == nb - 1);
         acc = 1'b0;
         guard = 0;
         while (!acc) begin
            acc = sb_tready;
            if (acc) begin
               if (i == 0) ts0 = rtc;
               check("b_pass_tdata", mb_tdata, sb_tdata);
               check("b_pass_ctl", {mb_tvalid, mb_tlast, sb_tready}, {sb_tvalid, sb_tlast, mb_tready});
            end
            tick();
            guard++;
            if (!acc && guard > 100) begin
               n_chk++; n_err++;
               $display("FAIL b_send_timeout: got no handshake expected one within 100 cycles");
               sb_tvalid = 1'b0; sb_tlast = 1'b0;
               return;
            end
         end
      end
      sb_tvalid = 1'b0;
      sb_tlast  = 1'b0;
   endtask

   task automatic drain_a();
      tsa_tready = 1'b1;
      for (int k = 0; k < 50 && tsa_tvalid; k++) tick();
      tick();
      check("a_drained_level", lvla, 0);
   endtask

   initial begin
      logic [63:0] ts0;
      rst_n = 1'b0; rtc = '0; tog_b = 1'b0;
      sa_tdata = '0; sa_tvalid = 1'b0; sa_tlast = 1'b0; ma_tready = 1'b1; tsa_tready = 1'b1;
      sb_tdata = '0; sb_tvalid = 1'b0; sb_tlast = 1'b0; mb_tready = 1'b1; tsb_tready = 1'b1;
      repeat (3) tick();

      // Reset values and transparent data path while in reset.
      check("rst_level", lvla, 0);
      check("rst_tvalid", tsa_tvalid, 0);
      check("rst_frame_cnt", fcnta, 0);
      check("rst_ovf", ovfa, 0);
      sa_tdata = 8'h5A; sa_tvalid = 1'b1; sa_tlast = 1'b1;
      #1;
      check("rst_pass", {ma_tdata, ma_tvalid, ma_tlast, sa_tready}, {8'h5A, 1'b1, 1'b1, 1'b1});
      sa_tvalid = 1'b0; sa_tlast = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Sync, SOF at rtc=1000.
      rtc = 64'd1000;
      build(16'h88F7, 1'b0, 4'h0, 16'h1234, 60);
      send_a(frm.size(), 1'b0, ts0);
      exp_a.push_back({4'h0, 16'h1234, 64'd1000});
      check("sync_tvalid_next", tsa_tvalid, 1);
      check("sync_frame_cnt", fcnta, 1);
      repeat (3) tick();

      // VLAN-tagged Pdelay_Req on the byte-wide path.
      build(16'h88F7, 1'b1, 4'h2, 16'h55AA, 64);
      send_a(frm.size(), 1'b0, ts0);
      exp_a.push_back({4'h2, 16'h55AA, ts0});
      repeat (3) tick();

      // IPv4, Announce and truncated PTP: no records.
      build(16'h0800, 1'b0, 4'h0, 16'h1111, 60);
      send_a(frm.size(), 1'b0, ts0);
      build(16'h88F7, 1'b0, 4'hB, 16'h2222, 60);
      send_a(frm.size(), 1'b0, ts0);
      build(16'h88F7, 1'b0, 4'h0, 16'h3333, 40);
      send_a(frm.size(), 1'b0, ts0);
      repeat (3) tick();
      check("noevt_frame_cnt", fcnta, 5);
      check("noevt_level", lvla, 0);

      // Highest event message type still produces a record.
      build(16'h88F7, 1'b0, 4'h3, 16'h4444, 60);
      send_a(frm.size(), 1'b0, ts0);
      exp_a.push_back({4'h3, 16'h4444, ts0});
      repeat (3) tick();

      // Six Syncs into a depth-4 FIFO with no reader.
      tsa_tready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         build(16'h88F7, 1'b0, 4'h0, 16'(16'h0100 + k), 60);
         send_a(frm.size(), 1'b0, ts0);
         if (k <= 4) exp_a.push_back({4'h0, 16'(16'h0100 + k), ts0});
      end
      check("ovf_level", lvla, 4);
      check("ovf_count", ovfa, 2);
      check("ovf_tvalid", tsa_tvalid, 1);

      // Push into a full FIFO while the head pops in the same cycle.
      build(16'h88F7, 1'b0, 4'h0, 16'h01FF, 60);
      send_a(frm.size(), 1'b1, ts0);
      exp_a.push_back({4'h0, 16'h01FF, ts0});
      check("fullpop_level", lvla, 4);
      check("fullpop_ovf", ovfa, 2);
      check("fullpop_frame_cnt", fcnta, 13);
      drain_a();

      // Reset in the middle of a PTP frame, then a clean Sync.
      build(16'h88F7, 1'b0, 4'h0, 16'h0999, 60);
      send_a(20, 1'b0, ts0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_frame_cnt", fcnta, 0);
      check("midrst_ovf", ovfa, 0);
      check("midrst_level", {lvla, tsa_tvalid}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      build(16'h88F7, 1'b0, 4'h0, 16'h0007, 60);
      send_a(frm.size(), 1'b0, ts0);
      exp_a.push_back({4'h0, 16'h0007, ts0});
      check("postrst_frame_cnt", fcnta, 1);
      drain_a();

      // 64-bit path: VLAN Delay_Req with downstream ready toggling every cycle.
      mb_tready = 1'b0;
      tog_b = 1'b1;
      build(16'h88F7, 1'b1, 4'h1, 16'hBEEF, 64);
      send_b(ts0);
      exp_b.push_back({4'h1, 16'hBEEF, ts0});
      repeat (4) tick();
      tog_b = 1'b0;
      check("b_frame_cnt", fcntb, 1);

      check("a_queue_empty", exp_a.size(), 0);
      check("b_queue_empty", exp_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
